// File: rtl/multicycle_controlunit_pkg.sv
// Shared encodings for the multicycle UWARM control unit: FSM states, ALU
// control values, data-processing command codes and ARM condition codes.
package multicycle_controlunit_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXER   = 4'd6,
    EXEI   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic dp_supported(input logic [3:0] cmd, input logic en_eor);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP: dp_supported = 1'b1;
      CMD_EOR:                                     dp_supported = en_eor;
      default:                                     dp_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] dp_alu_ctl(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: dp_alu_ctl = ALU_SUB;
      CMD_AND:          dp_alu_ctl = ALU_AND;
      CMD_ORR:          dp_alu_ctl = ALU_ORR;
      CMD_EOR:          dp_alu_ctl = ALU_EOR;
      default:          dp_alu_ctl = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controlunit_cond_check.sv
// ARM condition-code evaluation: cond field plus NZCV gives the execute
// qualifier. Purely combinational so the pipelined core can reuse it.
module multicycle_controlunit_cond_check
  import multicycle_controlunit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    ok = 1'b1;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL: ok = 1'b1;
      COND_NV: ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multicycle UWARM control FSM: sequences FETCH/DECODE/EXE/MEM/WB, owns the
// NZCV register and gates architectural writes with the registered cond_ok.
module multicycle_controlunit
  import multicycle_controlunit_pkg::*;
#(
  parameter int         ALUCTL_W = 3,
  parameter bit         EN_EOR   = 1'b1,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic [3:0]          flags,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [1:0]          imm_src,
  output logic [1:0]          reg_src,
  output logic                reg_write,
  output logic [3:0]          state_o
);

  state_t     state;
  logic [3:0] nzcv;
  logic       cond_ok;
  logic       cond_now;

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       is_cmp;
  logic       is_arith;
  logic       rd_pc;
  logic       unused_bits;

  assign cond     = instr[31:28];
  assign op       = instr[27:26];
  assign imm_bit  = instr[25];
  assign cmd      = instr[24:21];
  assign s_bit    = instr[20];
  assign rd       = instr[15:12];
  assign is_cmp   = (cmd == CMD_CMP);
  assign is_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);
  assign rd_pc    = (rd == 4'd15);
  assign unused_bits = ^{instr[19:16], instr[11:0]};

  assign imm_src = op;
  assign reg_src = {(op == OP_MEM) && !s_bit, (op == OP_BR)};
  assign state_o = state;

  multicycle_controlunit_cond_check u_cond_check (
    .cond (cond),
    .nzcv (nzcv),
    .ok   (cond_now)
  );

  // cond_ok is only captured in DECODE and flags only move on the EXE exit
  // edge, so a flag write never races the condition check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      nzcv    <= FLAG_RST;
      cond_ok <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          cond_ok <= cond_now;
          case (op)
            OP_MEM: state <= MEMADR;
            OP_BR:  state <= BRANCH;
            OP_DP: begin
              if (!dp_supported(cmd, EN_EOR)) state <= FETCH;
              else if (imm_bit)               state <= EXEI;
              else                            state <= EXER;
            end
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= s_bit ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXER, EXEI: begin
          if (cond_ok) begin
            if (is_cmp || s_bit)              nzcv[3:2] <= flags[3:2];
            if (is_cmp || (s_bit && is_arith)) nzcv[1:0] <= flags[1:0];
          end
          state <= ALUWB;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALUCTL_W'(ALU_ADD);
    reg_write   = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  adr_src   = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        pc_write   = cond_ok && rd_pc;
        reg_write  = cond_ok && !rd_pc;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ok;
      end
      EXER, EXEI: begin
        alu_src_b   = (state == EXEI) ? 2'b01 : 2'b00;
        alu_control = ALUCTL_W'(dp_alu_ctl(cmd));
      end
      ALUWB: begin
        pc_write  = cond_ok && !is_cmp && rd_pc;
        reg_write = cond_ok && !is_cmp && !rd_pc;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ok;
      end
      default: ;
    endcase
    // Reset holds state at FETCH; suppress its enables until release.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule
